// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared VRAM types, geometry constants and fill-engine state encoding
package vram_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int ADDR_W   = 15;
    localparam int PIX_W    = 13;

    typedef logic [PIX_W-1:0] pixel_t;

    // Colour field positions, also used by the display-side unpacker
    localparam int COL_R_HI = 12;
    localparam int COL_R_LO = 9;
    localparam int COL_G_HI = 8;
    localparam int COL_G_LO = 5;
    localparam int COL_B_HI = 4;
    localparam int COL_B_LO = 1;
    localparam int COL_A    = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VB = 2'd1,
        RUN     = 2'd2,
        DONE    = 2'd3
    } fill_state_t;

endpackage

// File: rtl/vram_fill_if.sv
// rtl/vram_fill_if.sv - fill command handshake and VRAM write port bundle
interface vram_fill_if
    import vram_pkg::*;
#(
    parameter int AW = ADDR_W
) ();

    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_x;
    logic [7:0]    cmd_y;
    logic [7:0]    cmd_w;
    logic [7:0]    cmd_h;
    pixel_t        cmd_color;
    logic          vblank;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    pixel_t        wr_data;
    logic          busy;
    logic          done;

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, vblank,
        output cmd_ready, wr_en, wr_addr, wr_data, busy, done
    );

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, vblank,
        input  cmd_ready, wr_en, wr_addr, wr_data, busy, done
    );

endinterface

// File: rtl/vram_fill_writer_rect_walker.sv
// rtl/vram_fill_writer_rect_walker.sv - row-major cx/cy/row_base walker over a fill rectangle
module rect_walker
    import vram_pkg::*;
#(
    parameter int WIDTH  = SCREEN_W,
    parameter int HEIGHT = SCREEN_H,
    parameter int ADDR_W = vram_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_advance,
    input  logic [7:0]        i_x,
    input  logic [7:0]        i_y,
    input  logic [7:0]        i_w,
    input  logic [7:0]        i_h,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last,
    output logic              o_in_bounds
);

    localparam int RB_W = ADDR_W + 1;

    logic [8:0]      r_cx;
    logic [8:0]      r_cy;
    logic [8:0]      r_x0;
    logic [8:0]      r_x_end;
    logic [8:0]      r_y_end;
    logic [RB_W-1:0] r_row_base;
    logic [RB_W-1:0] w_base_init;

    // Only multiply in the block: once per command, against a constant pitch
    assign w_base_init = RB_W'(i_y) * RB_W'(WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cx       <= '0;
            r_cy       <= '0;
            r_x0       <= '0;
            r_x_end    <= '0;
            r_y_end    <= '0;
            r_row_base <= '0;
        end else if (i_start) begin
            r_cx       <= {1'b0, i_x};
            r_cy       <= {1'b0, i_y};
            r_x0       <= {1'b0, i_x};
            r_x_end    <= {1'b0, i_x} + {1'b0, i_w} - 9'd1;
            r_y_end    <= {1'b0, i_y} + {1'b0, i_h} - 9'd1;
            r_row_base <= w_base_init;
        end else if (i_advance) begin
            if (r_cx == r_x_end) begin
                r_cx       <= r_x0;
                r_cy       <= r_cy + 9'd1;
                r_row_base <= r_row_base + RB_W'(WIDTH);
            end else begin
                r_cx <= r_cx + 9'd1;
            end
        end
    end

    assign o_last      = (r_cx == r_x_end) && (r_cy == r_y_end);
    assign o_in_bounds = (r_cx < 9'(WIDTH)) && (r_cy < 9'(HEIGHT));
    assign o_addr      = ADDR_W'(r_row_base + RB_W'(r_cx));

endmodule

// File: rtl/vram_fill_writer.sv
// rtl/vram_fill_writer.sv - rectangle fill engine writing VRAM pixels during vblank
module vram_fill_writer
    import vram_pkg::*;
#(
    parameter int WIDTH  = SCREEN_W,
    parameter int HEIGHT = SCREEN_H,
    parameter int ADDR_W = vram_pkg::ADDR_W
) (
    input  logic       clk,
    input  logic       rst,
    vram_fill_if.slave bus
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_WAIT_VB = WAIT_VB;
    localparam logic [1:0] S_RUN     = RUN;
    localparam logic [1:0] S_DONE    = DONE;

    logic [1:0]        r_state;
    pixel_t            r_color;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    pixel_t            r_wr_data;
    logic              r_done;

    logic              w_accept;
    logic              w_empty;
    logic              w_issue;
    logic              w_last;
    logic              w_in_bounds;
    logic [ADDR_W-1:0] w_addr;

    assign w_accept = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_empty  = (bus.cmd_w == 8'd0) || (bus.cmd_h == 8'd0);
    assign w_issue  = (r_state == S_RUN) && bus.vblank;

    rect_walker #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_walker (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_accept),
        .i_advance   (w_issue),
        .i_x         (bus.cmd_x),
        .i_y         (bus.cmd_y),
        .i_w         (bus.cmd_w),
        .i_h         (bus.cmd_h),
        .o_addr      (w_addr),
        .o_last      (w_last),
        .o_in_bounds (w_in_bounds)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_color <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_color <= bus.cmd_color;
                        r_state <= w_empty ? S_DONE : S_WAIT_VB;
                    end
                end
                S_WAIT_VB: if (bus.vblank) r_state <= S_RUN;
                S_RUN:     if (w_issue && w_last) r_state <= S_DONE;
                S_DONE:    r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Clipped pixels still take their cycle; they just never strobe the port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
        end else begin
            r_wr_en <= w_issue && w_in_bounds;
            r_done  <= (r_state == S_DONE);
            if (w_issue && w_in_bounds) begin
                r_wr_addr <= w_addr;
                r_wr_data <= r_color;
            end
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.done      = r_done;

endmodule

// File: doc/vram_fill_writer.md
# vram_fill_writer

Rectangle-fill write engine for the VRAM tile/sprite memories. It accepts fill commands (origin, size, 13-bit RGBA colour) over a valid/ready handshake and walks the rectangle row-major, one pixel per cycle. Each pixel is emitted on a VRAM write port. Writes happen only while `vblank` is high, so the display-side read path never sees a half-drawn frame. It sits between game logic and the write port of a `vram` instance; the display transformers and compositor stay on the read port.

## Interface
Parameters:
- `WIDTH`, 160, image width in pixels (row pitch of the VRAM).
- `HEIGHT`, 120, image height in pixels.
- `ADDR_W`, 15, VRAM address width; WIDTH*HEIGHT ≤ 2^ADDR_W.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine idle, can accept a command.
- `cmd_x`, `cmd_y` in 8 each: top-left pixel.
- `cmd_w`, `cmd_h` in 8 each: size in pixels; 0 is legal (empty).
- `cmd_color` in 13: pixel {R[12:9],G[8:5],B[4:1],A[0]}.
- `vblank` in 1: write window; high = writes allowed.
- `wr_en` out 1: write strobe to VRAM.
- `wr_addr` out ADDR_W: y*WIDTH + x.
- `wr_data` out 13: latched `cmd_color`.
- `busy` out 1: equals !`cmd_ready`.
- `done` out 1: one-cycle pulse on completion.

## Operation
- States: IDLE, WAIT_VB, RUN, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`&&`cmd_ready`, latch x, y, w, h and colour.
  - If w==0 or h==0, go to DONE.
  - Otherwise go to WAIT_VB with cx=x, cy=y, row_base=y*WIDTH.
- WAIT_VB: go to RUN when `vblank`=1.
- RUN: on each cycle with `vblank`=1, issue pixel (cx,cy) and advance row-major.
  - Column advance: cx+1 while cx < x+w-1.
  - Row wrap: cx=x, cy+1, row_base += WIDTH.
  - Cycles with `vblank`=0 pause: no issue, no advance. Resume at the same pixel.
  - The last pixel (cx=x+w-1, cy=y+h-1) moves to DONE.
- DONE: one cycle, then IDLE.
- Clipping: a pixel with cx ≥ WIDTH or cy ≥ HEIGHT consumes its cycle but produces no `wr_en`.
- Arithmetic:
  - cx and cy are 9-bit; x+w ≤ 510 never overflows.
  - row_base is ADDR_W+1 bits; clipped rows are never written, so it never aliases.
  - No multiplier in the pixel loop. row_base is an accumulator; y*WIDTH is computed once at accept.
- `cmd_valid` while busy is ignored; the command stays pending until `cmd_ready`.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `busy`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `done`=0.
- Reset mid-operation abandons the rectangle. No further writes; pixels already written stay.
- `wr_en`/`wr_addr`/`wr_data` are registered: a pixel issued in RUN cycle k appears in cycle k+1.
- `done` is registered and asserted in the cycle after DONE.
- `cmd_ready`/`busy` decode the state register directly, with no extra latency.
- N=w*h pixels with `vblank` held high, handshake at edge 0:
  - WAIT_VB in cycle 1.
  - RUN in cycles 2..N+1.
  - `wr_en` in cycles 3..N+2.
  - DONE in cycle N+2; `cmd_ready`=1 in cycle N+3; `done`=1 in cycle N+3.
- Empty command: DONE in cycle 1, `done` and `cmd_ready` in cycle 2, no `wr_en`.
- `vblank` falling in a RUN cycle: that cycle issues nothing. Its effect on `wr_en` is seen one cycle later.

## Structure
- Shared package `vram_pkg` holds:
  - `pixel_t` (13-bit logic).
  - `ADDR_W`, `SCREEN_W`, `SCREEN_H` constants.
  - The `fill_state_t` enum {IDLE, WAIT_VB, RUN, DONE}.
  - The colour field bit positions, shared with the display-side unpacking.
- One natural sub-module: `rect_walker`. It holds the cx/cy/row_base counters with inputs start/advance and outputs last and in_bounds. The FSM and output registers stay in `vram_fill_writer`.

## Test plan
- Reset, then fill x=2,y=3,w=3,h=2,colour=0x1FFF with `vblank`=1.
  - Expect exactly 6 writes at addr 482,483,484,642,643,644 in consecutive cycles 3..8.
  - Expect `done` in cycle 9.
- Same command with `vblank` toggled 2 on / 3 off.
  - Expect identical address order.
  - Expect no `wr_en` while `vblank`=0 (checked one cycle late).
  - Expect 6 writes total.
- Clip: x=158,y=118,w=4,h=4 on 160x120.
  - Expect only 4 writes: addr 19038,19039,19198,19199.
  - Expect `done` at cycle 19; 16 RUN cycles consumed.
- w=0,h=5: expect no writes, `done` and `cmd_ready` in cycle 2.
- Assert `rst` in the third write of a 10x10 fill.
  - Expect outputs zero and IDLE at once.
  - After release, a new 1x1 fill at (0,0) writes addr 0 exactly once.
- Hold `cmd_valid` with new data while busy: expect the command accepted only in the cycle `cmd_ready` rises, and its colour used.
